// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the ID-stage hazard logic.
//   mc_state_t      : multi-cycle tracker FSM states
//   FWD_REGFILE     : forwarding select value meaning "read the register file"
//   FWD_STAGE_BASE  : select value of stage 0; stage i is FWD_STAGE_BASE + i
//   fwd_sel_w(n)    : width of a forwarding select covering n stages plus the regfile
package pipeline_pkg;

  typedef enum logic [0:0] {
    MC_IDLE,
    MC_BUSY
  } mc_state_t;

  localparam int unsigned FWD_REGFILE    = 0;
  localparam int unsigned FWD_STAGE_BASE = 1;

  function automatic int unsigned fwd_sel_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Combinational forwarding priority matcher for one source operand.
//   live        : operand is really read (valid, used, not x0)
//   rs          : source register index
//   stage_rd    : packed destination registers, stage i at [i*W +: W]
//   stage_wr_en : stage i writes its rd
//   stage_ready : stage i result can be forwarded now
//   sel         : FWD_REGFILE, or FWD_STAGE_BASE + i for the youngest matching stage i
//   sel_ready   : stage_ready of the selected stage (1 when nothing matched)
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned FSW            = fwd_sel_w(NUM_FWD_STAGES)
) (
  input  logic                                     live,
  input  logic [REG_ADDR_WIDTH-1:0]                rs,
  input  logic [NUM_FWD_STAGES*REG_ADDR_WIDTH-1:0] stage_rd,
  input  logic [NUM_FWD_STAGES-1:0]                stage_wr_en,
  input  logic [NUM_FWD_STAGES-1:0]                stage_ready,
  output logic [FSW-1:0]                           sel,
  output logic                                     sel_ready
);

  always_comb begin
    sel       = FSW'(FWD_REGFILE);
    sel_ready = 1'b1;
    // Walk oldest to youngest so the youngest match is the one left standing.
    for (int i = int'(NUM_FWD_STAGES) - 1; i >= 0; i--) begin
      if (live && stage_wr_en[i] && (stage_rd[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == rs)) begin
        sel       = FSW'(i + int'(FWD_STAGE_BASE));
        sel_ready = stage_ready[i];
      end
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard unit: forwarding selects, stall generation, a register scoreboard and a
// tracker for one outstanding multi-cycle (MUL/DIV) op.
//   clk, rst                 : clock, synchronous active-high reset
//   id_*                     : instruction currently in ID
//   flush                    : kill the ID instruction (does not mask stall)
//   stage_rd/wr_en/ready     : downstream stages, stage 0 youngest
//   mc_done, mc_rd           : multi-cycle unit write-back this cycle
//   stall, issue             : combinational hold / advance of ID
//   fwd_sel1, fwd_sel2       : 0 = regfile, i+1 = stage i
//   mc_busy                  : an MC op is outstanding
//   stall_cnt                : saturating count of stalled cycles
//   err_spurious_done        : sticky, unexpected or mismatched mc_done
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_FWD_STAGES = 2,
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned FSW            = fwd_sel_w(NUM_FWD_STAGES)
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     id_valid,
  input  logic [REG_ADDR_WIDTH-1:0]                id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0]                id_rs2,
  input  logic                                     id_rs1_used,
  input  logic                                     id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0]                id_rd,
  input  logic                                     id_wr_en,
  input  logic                                     id_is_mc,
  input  logic                                     flush,
  input  logic [NUM_FWD_STAGES*REG_ADDR_WIDTH-1:0] stage_rd,
  input  logic [NUM_FWD_STAGES-1:0]                stage_wr_en,
  input  logic [NUM_FWD_STAGES-1:0]                stage_ready,
  input  logic                                     mc_done,
  input  logic [REG_ADDR_WIDTH-1:0]                mc_rd,
  output logic                                     stall,
  output logic                                     issue,
  output logic [FSW-1:0]                           fwd_sel1,
  output logic [FSW-1:0]                           fwd_sel2,
  output logic                                     mc_busy,
  output logic [CNT_WIDTH-1:0]                     stall_cnt,
  output logic                                     err_spurious_done
);

  localparam int unsigned NumRegs = 1 << REG_ADDR_WIDTH;

  mc_state_t                 state_q;
  logic [NumRegs-1:0]        sb_q;
  logic [REG_ADDR_WIDTH-1:0] track_rd_q;
  logic [CNT_WIDTH-1:0]      stall_cnt_q;
  logic                      err_q;

  logic rs1_live, rs2_live;
  logic sel1_ready, sel2_ready;
  logic load_use, raw_mc, waw_mc, struct_mc;

  assign rs1_live = id_valid & id_rs1_used & (id_rs1 != '0);
  assign rs2_live = id_valid & id_rs2_used & (id_rs2 != '0);

  fwd_select #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .FSW            (FSW)
  ) u_fwd_rs1 (
    .live        (rs1_live),
    .rs          (id_rs1),
    .stage_rd    (stage_rd),
    .stage_wr_en (stage_wr_en),
    .stage_ready (stage_ready),
    .sel         (fwd_sel1),
    .sel_ready   (sel1_ready)
  );

  fwd_select #(
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
    .NUM_FWD_STAGES (NUM_FWD_STAGES),
    .FSW            (FSW)
  ) u_fwd_rs2 (
    .live        (rs2_live),
    .rs          (id_rs2),
    .stage_rd    (stage_rd),
    .stage_wr_en (stage_wr_en),
    .stage_ready (stage_ready),
    .sel         (fwd_sel2),
    .sel_ready   (sel2_ready)
  );

  // Selects are already forced to the regfile when the operand is not live.
  assign load_use  = ((fwd_sel1 != FSW'(FWD_REGFILE)) & ~sel1_ready) |
                     ((fwd_sel2 != FSW'(FWD_REGFILE)) & ~sel2_ready);
  // No MC-result forwarding: a dependent op waits until the bit clears at mc_done.
  assign raw_mc    = (rs1_live & sb_q[id_rs1]) | (rs2_live & sb_q[id_rs2]);
  assign waw_mc    = id_wr_en & (id_rd != '0) & sb_q[id_rd];
  assign struct_mc = id_is_mc & (state_q != MC_IDLE);

  assign stall = id_valid & (load_use | raw_mc | waw_mc | struct_mc);
  assign issue = id_valid & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MC_IDLE;
      sb_q        <= '0;
      track_rd_q  <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
      end
      if (mc_done && ((state_q == MC_IDLE) || (mc_rd != track_rd_q))) begin
        err_q <= 1'b1;
      end
      unique case (state_q)
        MC_IDLE: begin
          if (issue && id_is_mc) begin
            state_q    <= MC_BUSY;
            track_rd_q <= id_rd;
            if (id_wr_en && (id_rd != '0)) begin
              sb_q[id_rd] <= 1'b1;
            end
          end
        end
        MC_BUSY: begin
          // Clear the tracked bit even on an mc_rd mismatch so the pipe cannot deadlock.
          if (mc_done) begin
            state_q          <= MC_IDLE;
            sb_q[track_rd_q] <= 1'b0;
          end
        end
        default: state_q <= MC_IDLE;
      endcase
    end
  end

  assign mc_busy           = (state_q == MC_BUSY);
  assign stall_cnt         = stall_cnt_q;
  assign err_spurious_done = err_q;

endmodule
